// File: rtl/uart_tx_if.sv
// Host-side connection of the UART transmitter: runtime config, TX FIFO read port
// and the serial line / status outputs.
interface uart_tx_if;
  logic [15:0] baud_divisor;
  logic [1:0]  i_parity_type;
  logic        i_stop_bits;
  logic        i_tx_en;
  logic [7:0]  i_fifo_data;
  logic        empty;
  logic        o_fifo_rd_en;
  logic        tx;
  logic        o_busy;
  logic        o_tx_done;

  modport master (
    output baud_divisor, i_parity_type, i_stop_bits, i_tx_en, i_fifo_data, empty,
    input  o_fifo_rd_en, tx, o_busy, o_tx_done
  );

  modport slave (
    input  baud_divisor, i_parity_type, i_stop_bits, i_tx_en, i_fifo_data, empty,
    output o_fifo_rd_en, tx, o_busy, o_tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops a byte from the TX FIFO and sends start, 8 data bits LSB
// first, optional parity and 1 or 2 stop bits at a runtime-programmable bit period.
module uart_tx #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  generate
    if (CLK_FREQ <= 0) begin : g_bad_freq
      $error("uart_tx: CLK_FREQ must be positive");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, LOAD, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT
  } state_t;

  state_t      state;
  logic [7:0]  shift_reg;
  logic [15:0] div_q;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  par_type;
  logic        par_bit;
  logic        stop2;
  logic        stop_idx;
  logic        tx_q;
  logic        baud_tick;
  logic        rd_en;

  assign baud_tick = (baud_cnt == div_q - 16'd1);
  // Pop decision is made in the IDLE cycle itself so the byte is on the bus during LOAD.
  assign rd_en     = !rst && (state == IDLE) && bus.i_tx_en && !bus.empty;

  assign bus.o_fifo_rd_en = rd_en;
  assign bus.tx           = tx_q;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_tx_done    = (state == STOP_BIT) && baud_tick && (stop_idx || !stop2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      div_q     <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      par_type  <= '0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      stop_idx  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      if (state != IDLE && state != LOAD)
        baud_cnt <= baud_tick ? 16'd0 : baud_cnt + 16'd1;

      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (rd_en) state <= LOAD;
        end
        LOAD: begin
          shift_reg <= bus.i_fifo_data;
          div_q     <= (bus.baud_divisor == 16'd0) ? 16'd1 : bus.baud_divisor;
          par_type  <= bus.i_parity_type;
          stop2     <= bus.i_stop_bits;
          case (bus.i_parity_type)
            2'b01:   par_bit <= ^bus.i_fifo_data;
            2'b10:   par_bit <= ~^bus.i_fifo_data;
            2'b11:   par_bit <= 1'b1;
            default: par_bit <= 1'b0;
          endcase
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          stop_idx  <= 1'b0;
          tx_q      <= 1'b0;
          state     <= START_BIT;
        end
        START_BIT: begin
          if (baud_tick) begin
            tx_q  <= shift_reg[0];
            state <= DATA_BITS;
          end
        end
        DATA_BITS: begin
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (par_type != 2'b00) begin
                tx_q  <= par_bit;
                state <= PARITY_BIT;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP_BIT;
              end
            end else begin
              // Drive the next bit now; shift_reg[0] is the bit just sent.
              tx_q <= shift_reg[1];
            end
          end
        end
        PARITY_BIT: begin
          if (baud_tick) begin
            tx_q  <= 1'b1;
            state <= STOP_BIT;
          end
        end
        STOP_BIT: begin
          if (baud_tick) begin
            if (stop2 && !stop_idx) stop_idx <= 1'b1;
            else                    state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a per-cycle frame model built from the framing rules,
// compared every cycle, plus literal timing/bit checks for each scenario.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if bus();
  uart_tx #(.CLK_FREQ(50000000)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic tx; logic busy; logic done; } ent_t;

  ent_t        plan[$];
  logic [7:0]  fifo_q[$];
  int          rd_hist[$];
  int          done_hist[$];
  logic        line_hist [0:8191];
  logic        busy_hist [0:8191];
  int          cyc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected line/busy/done for every cycle from the pop cycle's successor (LOAD) on.
  task automatic build_frame(input logic [7:0] d);
    int   dv;
    logic bits[$];
    dv = (bus.baud_divisor == 16'd0) ? 1 : int'(bus.baud_divisor);
    plan.push_back('{1'b1, 1'b1, 1'b0});
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    case (bus.i_parity_type)
      2'b01: bits.push_back(^d);
      2'b10: bits.push_back(~^d);
      2'b11: bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (bus.i_stop_bits) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < dv; k++) plan.push_back('{bits[i], 1'b1, 1'b0});
    plan[plan.size()-1].done = 1'b1;
  endtask

  task automatic sample();
    ent_t e;
    logic exp_rd;
    exp_rd = 1'b0;
    if (plan.size() > 0) e = plan.pop_front();
    else begin
      e = '{1'b1, 1'b0, 1'b0};
      exp_rd = !rst && bus.i_tx_en && !bus.empty;
      if (exp_rd) build_frame(fifo_q[0]);
    end
    chk("tx",    32'(bus.tx),           32'(e.tx));
    chk("busy",  32'(bus.o_busy),       32'(e.busy));
    chk("rd_en", 32'(bus.o_fifo_rd_en), 32'(exp_rd));
    chk("done",  32'(bus.o_tx_done),    32'(e.done));
    if (rst) plan.delete();
    if (bus.o_fifo_rd_en === 1'b1) rd_hist.push_back(cyc);
    if (bus.o_tx_done === 1'b1)    done_hist.push_back(cyc);
    line_hist[cyc] = bus.tx;
    busy_hist[cyc] = bus.o_busy;
  endtask

  // One cycle: check mid-cycle, then advance and service a FIFO pop seen last cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
      if (rd_hist.size() > 0 && rd_hist[rd_hist.size()-1] == cyc - 1 && fifo_q.size() > 0) begin
        bus.i_fifo_data = fifo_q.pop_front();
        bus.empty = (fifo_q.size() == 0);
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.empty = 1'b0;
  endtask

  task automatic cfg(input int dv, input int pt, input int sb);
    bus.baud_divisor  = 16'(dv);
    bus.i_parity_type = 2'(pt);
    bus.i_stop_bits   = 1'(sb);
  endtask

  task automatic wait_done(input int n, input int budget);
    int d0, k;
    d0 = done_hist.size();
    k = 0;
    while (done_hist.size() < d0 + n && k < budget) begin step(1); k++; end
    chk("done_timeout", 32'(done_hist.size() >= d0 + n), 32'd1);
  endtask

  task automatic wait_rd(input int budget);
    int r0, k;
    r0 = rd_hist.size();
    k = 0;
    while (rd_hist.size() == r0 && k < budget) begin step(1); k++; end
    chk("rd_timeout", 32'(rd_hist.size() > r0), 32'd1);
  endtask

  int t, t2, r0, d0, bad;
  int pexp[4];
  int plen[4];

  initial begin
    rst = 1'b1;
    cyc = 0;
    bus.i_tx_en = 1'b0;
    bus.i_fifo_data = 8'h00;
    bus.empty = 1'b1;
    cfg(4, 0, 0);
    pexp = '{0, 0, 1, 1};
    plen = '{0, 89, 89, 97};
    @(posedge clk);
    #1;
    step(3);
    rst = 1'b0;
    chk("reset_tx",   32'(line_hist[1]), 32'd1);
    chk("reset_busy", 32'(busy_hist[1]), 32'd0);
    step(2);

    // 0x55, div 4, no parity, one stop
    cfg(4, 0, 0);
    push(8'h55);
    bus.i_tx_en = 1'b1;
    wait_done(1, 200);
    t = rd_hist[rd_hist.size()-1];
    chk("f55_len",    32'(done_hist[done_hist.size()-1] - t), 32'd41);
    chk("f55_load",   32'(line_hist[t+1]),  32'd1);
    chk("f55_start0", 32'(line_hist[t+2]),  32'd0);
    chk("f55_start3", 32'(line_hist[t+5]),  32'd0);
    chk("f55_b0",     32'(line_hist[t+6]),  32'd1);
    chk("f55_b1",     32'(line_hist[t+10]), 32'd0);
    chk("f55_b7",     32'(line_hist[t+37]), 32'd0);
    chk("f55_stop",   32'(line_hist[t+38]), 32'd1);
    step(2);

    // 0xA5, div 8, parity even/odd/mark; mark run uses two stop bits
    for (int pt = 1; pt < 4; pt++) begin
      cfg(8, pt, (pt == 3) ? 1 : 0);
      push(8'hA5);
      wait_done(1, 300);
      t = rd_hist[rd_hist.size()-1];
      chk("a5_len", 32'(done_hist[done_hist.size()-1] - t), 32'(plen[pt]));
      chk("a5_par", 32'(line_hist[t+2+72+4]), 32'(pexp[pt]));
      step(1);
    end

    // Back-to-back 0x0F, 0xF0 at div 2
    bus.i_tx_en = 1'b0;
    cfg(2, 0, 0);
    push(8'h0F);
    push(8'hF0);
    r0 = rd_hist.size();
    bus.i_tx_en = 1'b1;
    wait_done(2, 200);
    step(3);
    chk("b2b_rd_cnt", 32'(rd_hist.size() - r0), 32'd2);
    t  = rd_hist[r0];
    t2 = rd_hist[r0+1];
    chk("b2b_gap",    32'(t2 - t), 32'd22);
    chk("b2b_stop1",  32'(line_hist[t+21]), 32'd1);
    chk("b2b_idle",   32'(line_hist[t2+1]), 32'd1);
    chk("b2b_start2", 32'(line_hist[t2+2]), 32'd0);
    chk("b2b_b0_2",   32'(line_hist[t2+4]), 32'd0);

    // Empty FIFO with tx enabled: nothing moves
    r0 = rd_hist.size();
    step(100);
    bad = 0;
    for (int i = cyc - 100; i < cyc; i++)
      if (line_hist[i] !== 1'b1 || busy_hist[i] !== 1'b0) bad++;
    chk("empty_rd",   32'(rd_hist.size() - r0), 32'd0);
    chk("empty_line", 32'(bad), 32'd0);

    // Drop i_tx_en mid-frame: current frame completes, the queued byte waits
    cfg(2, 0, 0);
    push(8'hAA);
    push(8'h33);
    r0 = rd_hist.size();
    d0 = done_hist.size();
    wait_rd(20);
    step(5);
    bus.i_tx_en = 1'b0;
    step(60);
    chk("txen_done", 32'(done_hist.size() - d0), 32'd1);
    chk("txen_rd",   32'(rd_hist.size() - r0),   32'd1);
    bus.i_tx_en = 1'b1;
    wait_done(1, 100);
    chk("txen_rd2",  32'(rd_hist.size() - r0),   32'd2);
    step(2);

    // Reset during data bit 3
    cfg(4, 0, 0);
    push(8'h00);
    wait_rd(20);
    t = rd_hist[rd_hist.size()-1];
    while (cyc < t + 19) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    chk("rst_tx",   32'(line_hist[t+20]), 32'd1);
    chk("rst_busy", 32'(busy_hist[t+20]), 32'd0);
    r0 = rd_hist.size();
    step(50);
    chk("rst_no_rd", 32'(rd_hist.size() - r0), 32'd0);

    // Divisor 0 behaves as 1; mid-frame divisor change ignored
    cfg(0, 0, 0);
    push(8'h81);
    wait_rd(20);
    step(2);
    bus.baud_divisor = 16'd9;
    wait_done(1, 100);
    chk("d0_len",  32'(done_hist[done_hist.size()-1] - t - 0) - 32'(rd_hist[rd_hist.size()-1] - t), 32'd11);
    t = rd_hist[rd_hist.size()-1];
    chk("d0_start", 32'(line_hist[t+2]),  32'd0);
    chk("d0_b0",    32'(line_hist[t+3]),  32'd1);
    chk("d0_b1",    32'(line_hist[t+4]),  32'd0);
    chk("d0_b7",    32'(line_hist[t+10]), 32'd1);
    chk("d0_stop",  32'(line_hist[t+11]), 32'd1);
    step(2);

    cfg(3, 0, 0);
    push(8'h3C);
    wait_rd(20);
    step(4);
    bus.baud_divisor = 16'd7;
    wait_done(1, 200);
    t = rd_hist[rd_hist.size()-1];
    chk("d3_len", 32'(done_hist[done_hist.size()-1] - t), 32'd31);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
